// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter grant stage: FSM state codes, the default
// lock-tenure bound and a one-hot to binary index helper.
// Optional feature macro used by the grant stage: ARB_HOLD_LIMIT_EN.
package arb_pkg;

   // Default bound on how many cycles a locked owner may keep the grant.
   localparam int ARB_MAX_HOLD_DEFAULT = 16;

   // State codes as plain constants so legacy code can compare against them directly.
   localparam logic [1:0] ST_ARB = 2'd0;
   localparam logic [1:0] ST_OWN = 2'd1;
   localparam logic [1:0] ST_REL = 2'd2;

   // Named view of the same encoding, handy for debug and waveform decoding.
   typedef enum logic [1:0] {
      ARB = ST_ARB,
      OWN = ST_OWN,
      REL = ST_REL
   } arb_state_e;

   // OR together the indices of all set bits; exact for one-hot or all-zero input.
   function automatic int unsigned onehot_to_idx(input logic [31:0] vec);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (vec[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/onehot_mask_pick.sv
// Combinational lowest-set-bit picker: output has only the lowest set bit of
// the input, or is all-zero when the input is all-zero.
module onehot_mask_pick
   import arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] bits,
   output logic [N_REQ-1:0] lowest
);

   // Two's complement isolates the lowest set bit.
   assign lowest = bits & (~bits + N_REQ'(1));

endmodule

// File: rtl/arb_grant_sequencer.sv
// Registered grant stage for the shared-bus arbiter. Picks one requesting
// master with round-robin priority, holds the grant until the bus reports the
// transfer done (or the owner abandons it), and inserts one idle cycle between
// owners. Lock lets an owner keep the bus across several transfers.
// Optional feature macro: ARB_HOLD_LIMIT_EN bounds lock tenure to MAX_HOLD
// cycles and pulses hold_expired when the bound forces a release.
module arb_grant_sequencer
   import arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
   parameter int W_IDX    = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] lock,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic [W_IDX-1:0] gnt_idx,
   output logic             hold_expired
);

   if (N_REQ < 2 || MAX_HOLD < 2) begin : g_param_check
      $error("arb_grant_sequencer: N_REQ and MAX_HOLD must both be >= 2");
   end

   logic [1:0]       state;
   logic [N_REQ-1:0] mask;
   logic [N_REQ-1:0] masked;
   logic [N_REQ-1:0] cand;
   logic [N_REQ-1:0] pick;
   logic [N_REQ-1:0] pick_mask;
   logic             own_lock;
   logic             own_req;
   logic             expire_now;
   logic             release_now;

   // Prefer masters above the previous owner; fall back to all requesters
   // when none remain above it (round-robin wrap-around).
   assign masked    = req & ~mask;
   assign cand      = (|masked) ? masked : req;
   assign pick_mask = pick | (pick - N_REQ'(1));

   onehot_mask_pick #(.N_REQ(N_REQ)) u_pick (
      .bits   (cand),
      .lowest (pick)
   );

   assign own_lock = |(lock & gnt);
   assign own_req  = |(req & gnt);

   // Owner leaves on an unlocked done, on forced expiry, or when it drops its
   // request while idle and unlocked.
   assign release_now = (state == ST_OWN) &&
                        ((done && !own_lock) || expire_now ||
                         (!done && !own_req && !own_lock));

`ifdef ARB_HOLD_LIMIT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   logic [CNT_W-1:0] cnt;

   assign expire_now = (state == ST_OWN) && done && own_lock &&
                       (cnt >= CNT_W'(MAX_HOLD - 1));

   // Tenure counter: zero outside ownership, saturating count while owning;
   // hold_expired marks the first release cycle after a forced drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         hold_expired <= 1'b0;
      end else begin
         hold_expired <= expire_now;
         if (state != ST_OWN)
            cnt <= '0;
         else if (cnt != CNT_W'(MAX_HOLD))
            cnt <= cnt + CNT_W'(1);
      end
   end
`else
   assign expire_now   = 1'b0;
   assign hold_expired = 1'b0;
`endif

   // Grant FSM: arbitrate, own, release. The release cycle also arbitrates so
   // the bus sees exactly one idle cycle between owners.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values and ordering inside the block is irrelevant.
      if (rst) begin
         state     <= ST_ARB;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         mask      <= '0;
      end else begin
         case (state)
            ST_ARB, ST_REL: begin
               if (|req) begin
                  state     <= ST_OWN;
                  gnt       <= pick;
                  gnt_valid <= 1'b1;
                  gnt_idx   <= W_IDX'(onehot_to_idx(32'(pick)));
                  mask      <= pick_mask;
               end else begin
                  state <= ST_ARB;
               end
            end
            ST_OWN: begin
               if (release_now) begin
                  state     <= ST_REL;
                  gnt       <= '0;
                  gnt_valid <= 1'b0;
                  gnt_idx   <= '0;
               end
            end
            default: state <= ST_ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_arb_grant_sequencer.sv
// Self-checking bench for arb_grant_sequencer (N_REQ=4, MAX_HOLD=4).
// Directed scenarios followed by random traffic, all compared every cycle
// against an owner/last-owner round-robin model. Honours ARB_HOLD_LIMIT_EN.
module tb_arb_grant_sequencer;

   localparam int N  = 4;
   localparam int MH = 4;
`ifdef ARB_HOLD_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] lock;
   logic         done;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [1:0]   gnt_idx;
   logic         hold_expired;

   int checks = 0;
   int errors = 0;

   // Reference model state: current owner (-1 none), last owner for rotation,
   // cycles the current owner has held the grant, expected hold_expired.
   int m_owner  = -1;
   int m_last   = -1;
   int m_tenure = 0;
   bit m_hexp   = 1'b0;

   logic [N-1:0] prev_gnt = '0;
   logic         prev_rst = 1'b1;

   always #5 clk = ~clk;

   arb_grant_sequencer #(.N_REQ(N), .MAX_HOLD(MH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .lock         (lock),
      .done         (done),
      .gnt          (gnt),
      .gnt_valid    (gnt_valid),
      .gnt_idx      (gnt_idx),
      .hold_expired (hold_expired)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // First requester strictly after the last owner, wrapping around.
   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_owner  = -1;
         m_last   = -1;
         m_tenure = 0;
         m_hexp   = 1'b0;
      end else if (m_owner >= 0) begin
         bit lk;
         bit expire;
         lk     = lock[m_owner];
         expire = LIMIT && done && lk && (m_tenure >= MH);
         if ((done && !lk) || expire || (!done && !req[m_owner] && !lk)) begin
            m_owner = -1;
            m_hexp  = expire;
         end else begin
            m_tenure++;
         end
      end else begin
         m_hexp = 1'b0;
         if (req != '0) begin
            m_owner  = rr_pick(req, m_last);
            m_last   = m_owner;
            m_tenure = 1;
         end
      end
   endtask

   task automatic compare();
      logic [N-1:0] exp_gnt;
      int           exp_idx;
      exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      exp_idx = (m_owner >= 0) ? m_owner : 0;
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("gnt_idx", 32'(gnt_idx), 32'(exp_idx));
      check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      check("hold_expired", 32'(hold_expired), 32'(m_hexp));
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      check("valid_vs_gnt", 32'(gnt_valid), 32'(|gnt));
      check("idx_vs_gnt", 32'(gnt_valid ? (gnt == (N'(1) << gnt_idx)) : (gnt_idx == '0)), 32'd1);
      check("no_direct_switch",
            32'(prev_gnt != '0 && gnt != '0 && gnt != prev_gnt && !prev_rst), 32'd0);
      prev_gnt = gnt;
      prev_rst = rst;
   endtask

   task automatic cyc(input logic r, input logic [N-1:0] q, input logic [N-1:0] l, input logic d);
      rst  = r;
      req  = q;
      lock = l;
      done = d;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   initial begin
      rst = 1'b1; req = '0; lock = '0; done = 1'b0;
      @(negedge clk);

      // Reset state
      cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
      cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
      check("rst_gnt", 32'(gnt), 32'd0);

      // Grant one cycle after request, lowest index wins
      cyc(1'b0, 4'b0110, 4'b0000, 1'b0);
      check("t1_gnt", 32'(gnt), 32'b0010);
      check("t1_idx", 32'(gnt_idx), 32'd1);

      // Done releases for one cycle, then rotation to idx2
      cyc(1'b0, 4'b0110, 4'b0000, 1'b1);
      check("t2_rel", 32'(gnt), 32'd0);
      cyc(1'b0, 4'b0110, 4'b0000, 1'b0);
      check("t2_rot", 32'(gnt), 32'b0100);

      // Owner idx2 abandons, idx3 takes over
      cyc(1'b0, 4'b1000, 4'b0000, 1'b0);
      check("abandon_rel", 32'(gnt), 32'd0);
      cyc(1'b0, 4'b1000, 4'b0000, 1'b0);
      check("abandon_next", 32'(gnt), 32'b1000);

      // Owner idx3 done -> wrap-around to idx0
      cyc(1'b0, 4'b1001, 4'b0000, 1'b1);
      check("t3_rel", 32'(gnt), 32'd0);
      cyc(1'b0, 4'b1001, 4'b0000, 1'b0);
      check("t3_wrap", 32'(gnt), 32'b0001);

      // Reach owner idx2, then drop all requests: stays idle
      cyc(1'b0, 4'b0100, 4'b0000, 1'b1);
      cyc(1'b0, 4'b0100, 4'b0000, 1'b0);
      check("t5_own", 32'(gnt), 32'b0100);
      cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
      check("t5_rel", 32'(gnt), 32'd0);
      cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
      cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
      check("t5_idle", 32'(gnt), 32'd0);

      // Locked owner idx0 with done every cycle
      cyc(1'b0, 4'b0011, 4'b0001, 1'b1);
      check("t4_own", 32'(gnt), 32'b0001);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 4'b0011, 4'b0001, 1'b1);
         check("t4_hold", 32'(gnt), 32'b0001);
      end
      cyc(1'b0, 4'b0011, 4'b0001, 1'b1);
`ifdef ARB_HOLD_LIMIT_EN
      check("t4_drop", 32'(gnt), 32'd0);
      check("t4_expired", 32'(hold_expired), 32'd1);
      cyc(1'b0, 4'b0011, 4'b0000, 1'b0);
      check("t4_next", 32'(gnt), 32'b0010);
      check("t4_pulse_end", 32'(hold_expired), 32'd0);
`else
      check("t4_locked", 32'(gnt), 32'b0001);
      check("t4_no_expire", 32'(hold_expired), 32'd0);
`endif

      // Reset while owning drops grant at once, then grant without release cycle
      cyc(1'b1, 4'b0011, 4'b0000, 1'b0);
      check("t6_rst_gnt", 32'(gnt), 32'd0);
      check("t6_rst_valid", 32'(gnt_valid), 32'd0);
      cyc(1'b0, 4'b1000, 4'b0000, 1'b0);
      check("t6_regrant", 32'(gnt), 32'b1000);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic         r;
         logic [N-1:0] q;
         logic [N-1:0] l;
         logic         d;
         r = ($urandom_range(99) == 0);
         q = N'($urandom);
         l = ($urandom_range(3) == 0) ? N'($urandom) : '0;
         d = ($urandom_range(2) == 0);
         cyc(r, q, l, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
